// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer between writeback and fetch: latches the redirect
// target, flushes upstream stages for FLUSH_CYCLES, then holds a redirect until fetch accepts.
module flush_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned PC_W         = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid,
  input  logic            wb_exc,
  input  logic            wb_tlbr,
  input  logic            wb_ertn,
  input  logic            wb_refetch,
  input  logic [PC_W-1:0] wb_refetch_pc,
  input  logic [PC_W-1:0] csr_eentry,
  input  logic [PC_W-1:0] csr_tlbrentry,
  input  logic [PC_W-1:0] csr_era,
  input  logic            fe_redir_ready,
  output logic            flush_pipe,
  output logic            fe_hold,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  output logic            busy,
  output logic [15:0]     evt_cnt,
  output logic            drop_err
);

  // state   | meaning
  // S_IDLE  | waiting for a writeback event
  // S_DRAIN | flushing upstream stages, counter running down
  // S_REDIR | redirect pending until fetch accepts it
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REDIR} state_t;

  localparam logic [3:0]      LP_FLUSH  = 4'(FLUSH_CYCLES);
  localparam logic [PC_W-1:0] LP_PCMASK = ~(PC_W'(3));

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            w_ev;
  logic [PC_W-1:0] w_target;

  assign w_ev = wb_valid & (wb_exc | wb_tlbr | wb_ertn | wb_refetch);

  always_comb begin
    w_target = wb_refetch_pc;
    if (wb_tlbr)      w_target = csr_tlbrentry;
    else if (wb_exc)  w_target = csr_eentry;
    else if (wb_ertn) w_target = csr_era;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      flush_pipe  <= 1'b0;
      fe_hold     <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      busy        <= 1'b0;
      evt_cnt     <= 16'd0;
      drop_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ev) begin
            redir_pc   <= w_target & LP_PCMASK;
            r_cnt      <= LP_FLUSH;
            evt_cnt    <= evt_cnt + 16'd1;
            r_state    <= S_DRAIN;
            flush_pipe <= 1'b1;
            fe_hold    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_ev) drop_err <= 1'b1;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= S_REDIR;
            flush_pipe  <= 1'b0;
            redir_valid <= 1'b1;
          end
        end
        S_REDIR: begin
          // handshake cycle still counts as busy for dropped events
          if (w_ev) drop_err <= 1'b1;
          if (fe_redir_ready) begin
            r_state     <= S_IDLE;
            redir_valid <= 1'b0;
            fe_hold     <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          flush_pipe  <= 1'b0;
          fe_hold     <= 1'b0;
          redir_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Scoreboard bench for flush_redirect_ctrl: expected redirects are queued at event
// time and checked by a monitor at each fetch handshake; timing is checked inline.
module tb_flush_redirect_ctrl;
  localparam int unsigned FC   = 2;
  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            wb_valid = 1'b0, wb_exc = 1'b0, wb_tlbr = 1'b0, wb_ertn = 1'b0, wb_refetch = 1'b0;
  logic [PC_W-1:0] wb_refetch_pc = '0, csr_eentry = '0, csr_tlbrentry = '0, csr_era = '0;
  logic            fe_redir_ready = 1'b0;
  logic            flush_pipe, fe_hold, redir_valid, busy, drop_err;
  logic [PC_W-1:0] redir_pc;
  logic [15:0]     evt_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] cnt;
    logic        drop;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  flush_redirect_ctrl #(.FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_exc(wb_exc), .wb_tlbr(wb_tlbr), .wb_ertn(wb_ertn),
    .wb_refetch(wb_refetch), .wb_refetch_pc(wb_refetch_pc),
    .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era),
    .fe_redir_ready(fe_redir_ready),
    .flush_pipe(flush_pipe), .fe_hold(fe_hold), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .busy(busy), .evt_cnt(evt_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ev_clr();
    wb_valid = 0; wb_exc = 0; wb_tlbr = 0; wb_ertn = 0; wb_refetch = 0;
  endtask

  // wait (bounded) for redirect, handshake it; returns in the cycle after the handshake
  task automatic handshake(input string name);
    int n = 0;
    while (!redir_valid && n < 20) begin cyc(); n++; end
    chk({name, "_redir_seen"}, {31'd0, redir_valid}, 32'd1);
    fe_redir_ready = 1;
    cyc();
    fe_redir_ready = 0;
  endtask

  // monitor: compares the redirect presented at each fetch handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && redir_valid && fe_redir_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_redirect", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_redir_pc", redir_pc, e.pc);
          chk("sb_evt_cnt", {16'd0, evt_cnt}, {16'd0, e.cnt});
          chk("sb_drop_err", {31'd0, drop_err}, {31'd0, e.drop});
          chk("sb_fe_hold", {31'd0, fe_hold}, 32'd1);
        end
      end
    end
  end

  initial begin
    cyc(); cyc();
    chk("rst_flush", {31'd0, flush_pipe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_redir_valid", {31'd0, redir_valid}, 0);
    chk("rst_redir_pc", redir_pc, 0);
    chk("rst_evt_cnt", {16'd0, evt_cnt}, 0);
    chk("rst_drop_err", {31'd0, drop_err}, 0);
    resetn = 1;
    cyc();

    // basic exception, FC=2: flush cycles 1..2, redirect from 3, ready in 5
    csr_eentry = 32'h1C008000; wb_valid = 1; wb_exc = 1;
    sb_q.push_back('{32'h1C008000, 16'd1, 1'b0});
    cyc(); ev_clr(); csr_eentry = 32'hDEAD0000;                       // cycle 1
    chk("t1_c1_flush", {31'd0, flush_pipe}, 1);
    chk("t1_c1_hold", {31'd0, fe_hold}, 1);
    chk("t1_c1_rv", {31'd0, redir_valid}, 0);
    cyc();                                                            // cycle 2
    chk("t1_c2_flush", {31'd0, flush_pipe}, 1);
    cyc();                                                            // cycle 3
    chk("t1_c3_flush", {31'd0, flush_pipe}, 0);
    chk("t1_c3_rv", {31'd0, redir_valid}, 1);
    chk("t1_c3_pc", redir_pc, 32'h1C008000);
    cyc();                                                            // cycle 4
    chk("t1_c4_rv_held", {31'd0, redir_valid}, 1);
    cyc(); fe_redir_ready = 1;                                        // cycle 5
    cyc(); fe_redir_ready = 0;                                        // cycle 6
    chk("t1_c6_busy", {31'd0, busy}, 0);
    chk("t1_c6_rv", {31'd0, redir_valid}, 0);
    chk("t1_c6_evt", {16'd0, evt_cnt}, 1);
    cyc();

    // multiple flags: tlbr wins, one increment
    csr_tlbrentry = 32'h1C00F000; csr_eentry = 32'h1C008000; csr_era = 32'h1C00A000;
    wb_valid = 1; wb_exc = 1; wb_tlbr = 1; wb_ertn = 1;
    sb_q.push_back('{32'h1C00F000, 16'd2, 1'b0});
    cyc(); ev_clr();
    handshake("t2");
    cyc();

    // refetch with low bits cleared, then back-to-back ertn right after handshake
    wb_valid = 1; wb_refetch = 1; wb_refetch_pc = 32'h1C000107;
    sb_q.push_back('{32'h1C000104, 16'd3, 1'b0});
    cyc(); ev_clr();
    handshake("t3");                                                  // now cycle N+1
    chk("t6_idle_after_hs", {31'd0, busy}, 0);
    csr_era = 32'h1C001000; wb_valid = 1; wb_ertn = 1;
    sb_q.push_back('{32'h1C001000, 16'd4, 1'b0});
    cyc(); ev_clr();                                                  // cycle N+2
    chk("t6_flush", {31'd0, flush_pipe}, 1);
    handshake("t6");
    chk("t6_drop_err", {31'd0, drop_err}, 0);
    cyc();

    // events during DRAIN and REDIR are dropped
    csr_eentry = 32'h1C002000; wb_valid = 1; wb_exc = 1;
    sb_q.push_back('{32'h1C002000, 16'd5, 1'b1});
    cyc();                                                            // DRAIN
    wb_exc = 0; wb_tlbr = 1; csr_tlbrentry = 32'h1C0FF000;
    cyc(); ev_clr(); cyc();                                           // REDIR
    chk("t4_in_redir", {31'd0, redir_valid}, 1);
    csr_eentry = 32'h1C0EE000; wb_valid = 1; wb_exc = 1;
    cyc(); ev_clr();
    chk("t4_evt_unchanged", {16'd0, evt_cnt}, 5);
    chk("t4_pc_unchanged", redir_pc, 32'h1C002000);
    chk("t4_drop_err", {31'd0, drop_err}, 1);
    handshake("t4");
    cyc();
    wb_valid = 1; wb_refetch = 1; wb_refetch_pc = 32'h1C000200;
    sb_q.push_back('{32'h1C000200, 16'd6, 1'b1});
    cyc(); ev_clr();
    handshake("t4b");
    cyc();

    // reset mid-sequence aborts
    csr_eentry = 32'h1C003000; wb_valid = 1; wb_exc = 1;
    cyc(); ev_clr();                                                  // cycle 1
    cyc(); resetn = 0;                                                // cycle 2
    cyc(); resetn = 1;                                                // cycle 3
    chk("t5_flush", {31'd0, flush_pipe}, 0);
    chk("t5_rv", {31'd0, redir_valid}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_evt", {16'd0, evt_cnt}, 0);
    chk("t5_drop_err", {31'd0, drop_err}, 0);
    cyc();
    csr_era = 32'h1C004002; wb_valid = 1; wb_ertn = 1;
    sb_q.push_back('{32'h1C004000, 16'd1, 1'b0});
    cyc(); ev_clr();
    chk("t5_post_flush", {31'd0, flush_pipe}, 1);
    handshake("t5");
    cyc(); cyc();

    chk("sb_queue_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
Pipeline flush and redirect sequencer that sits between the writeback stage and instruction fetch. It accepts one retiring event per cycle from writeback: an exception, a TLB-refill exception, an ertn, or a refetch. It latches the redirect target, drives a multi-cycle flush to all upstream stages, and then holds a redirect request to fetch until fetch accepts it. Fetch is stalled for the whole sequence.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush_pipe is asserted; legal range 1..15.
PC_W, 32, width of all PC/address ports.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
wb_valid  in  1  writeback stage holds a valid instruction this cycle
wb_exc  in  1  instruction raises a non-refill exception (target csr_eentry)
wb_tlbr  in  1  instruction raises a TLB-refill exception (target csr_tlbrentry)
wb_ertn  in  1  instruction is ertn (target csr_era)
wb_refetch  in  1  instruction requests refetch of the next instruction (target wb_refetch_pc)
wb_refetch_pc  in  PC_W  refetch target
csr_eentry  in  PC_W  current EENTRY CSR value
csr_tlbrentry  in  PC_W  current TLBRENTRY CSR value
csr_era  in  PC_W  current ERA CSR value
fe_redir_ready  in  1  fetch accepts the redirect this cycle
flush_pipe  out  1  flush all IF/ID/EXE/MEM/WB valid bits
fe_hold  out  1  fetch must not issue new requests
redir_valid  out  1  redirect request to fetch is pending
redir_pc  out  PC_W  redirect target, bits [1:0] forced to 0
busy  out  1  controller is not in IDLE
evt_cnt  out  16  accepted-event count; wraps 0xFFFF->0
drop_err  out  1  sticky flag: an event arrived while busy

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; flush_pipe, fe_hold, redir_valid, busy, drop_err = 0; redir_pc = 0; evt_cnt = 0; internal counter = 0. Reset mid-sequence aborts the sequence immediately, with no pending redirect kept.
- An event is defined as ev = wb_valid & (wb_exc | wb_tlbr | wb_ertn | wb_refetch).
- Target priority is fixed: wb_tlbr -> csr_tlbrentry; else wb_exc -> csr_eentry; else wb_ertn -> csr_era; else wb_refetch -> wb_refetch_pc. The target is sampled in the event cycle only; later CSR changes do not affect it.
- States are IDLE, DRAIN and REDIR. All outputs are registered and derived from state.
- IDLE:
  - On ev at an edge: latch the target into redir_pc with [1:0] cleared, load the counter with FLUSH_CYCLES, increment evt_cnt, and go to DRAIN.
  - With no ev, stay in IDLE.
- DRAIN:
  - flush_pipe=1, fe_hold=1, busy=1.
  - The counter decrements each cycle. When the counter is 1 at an edge, go to REDIR.
  - With event in cycle 0, flush_pipe is high in cycles 1..FLUSH_CYCLES.
- REDIR:
  - redir_valid=1, fe_hold=1, busy=1, flush_pipe=0. redir_pc is held stable.
  - Stays in REDIR until fe_redir_ready=1. The handshake cycle is the last cycle redir_valid is high.
  - The next state after the handshake is IDLE, with all outputs low in the following cycle.
- Events while busy (DRAIN or REDIR, including the handshake cycle) are ignored: no target change, no evt_cnt increment, and drop_err is set to 1. drop_err clears only on reset.
- An event in the first IDLE cycle after the handshake is accepted normally, giving back-to-back sequences.
- fe_redir_ready is ignored outside REDIR.
- Minimum sequence latency: event cycle 0 -> redir_valid first high at cycle FLUSH_CYCLES+1.
- Multiple event flags in one cycle count as a single event: one evt_cnt increment, with the target chosen by priority.

Test Plan:
- FLUSH_CYCLES=2, csr_eentry=0x1C008000, wb_valid=1 and wb_exc=1 in cycle 0 -> flush_pipe=1 in cycles 1 and 2; redir_valid=1 and redir_pc=0x1C008000 from cycle 3; with fe_redir_ready=1 in cycle 5, busy=0 in cycle 6 and evt_cnt=1.
- wb_exc=1, wb_tlbr=1 and wb_ertn=1 in the same cycle, with csr_tlbrentry=0x1C00F000 -> redir_pc=0x1C00F000; evt_cnt increments by exactly 1.
- wb_refetch=1, wb_refetch_pc=0x1C000107 -> redir_pc=0x1C000104.
- Events sent in DRAIN and again in REDIR -> redir_pc unchanged, evt_cnt unchanged, drop_err=1 and remains 1 through later sequences.
- Event in cycle 0, then resetn=0 in cycle 2 -> in cycle 3 flush_pipe=0, redir_valid=0, busy=0, evt_cnt=0; the next event sequences normally.
- Handshake in cycle N and a new wb_ertn with csr_era=0x1C001000 in cycle N+1 -> accepted, flush_pipe=1 at N+2, redir_pc=0x1C001000, drop_err stays 0.
